// File: rtl/fft_arb_pkg.sv
// fft_arb_pkg
// Shared definitions for the FFT frame arbiter. This is the fft_inc
// definition set: default core geometry (stage count, sample widths),
// the arbiter FSM encoding, and the default WAIT-state watchdog limit.
package fft_arb_pkg;

  // Default FFT core geometry.
  localparam int TOTAL_STAGE = 8;
  localparam int REAL_WIDTH  = 16;
  localparam int IMGN_WIDTH  = 16;

  // The watchdog allows this many frame lengths in WAIT before giving up.
  localparam int TIMEOUT_FRAMES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  // Default watchdog limit in cycles for a core of 2^stage points.
  function automatic int fft_timeout(input int stage);
    return TIMEOUT_FRAMES * (1 << stage);
  endfunction

endpackage

// File: rtl/fft_arb_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. When both channels request, the channel
// that was not granted last wins; a single requester always wins. The
// last-grant register only moves when the parent accepts the grant.
// Ports:
//   iclk, rst_n : clock, asynchronous active-low reset
//   req         : per-channel request
//   update      : parent is taking the current grant this cycle
//   grant       : combinational one-hot grant (zero when no request)
module rr_arb2 (
  input  logic       iclk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // Index of the last granted channel. Resets to 1 so channel 0 wins first.
  logic last_q, last_d;

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
    last_d = last_q;
    if (update && (|req)) begin
      last_d = grant[1];
    end
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fft_arb.sv
// fft_arb
// Shares one FFT core between two sample channels, one frame at a time.
// A granted channel streams N = 2^STAGE samples into the core load port;
// the block then waits for the core to produce results, forwards N result
// beats tagged with the channel id, pulses done for that channel and
// returns to arbitration. A watchdog aborts a frame whose results never
// arrive and raises a sticky err flag, cleared by the next grant.
// Ports:
//   iclk, rst_n                          : clock, async active-low reset
//   req[1:0], gnt[1:0]                   : frame request / one-hot grant
//   s_real, s_imag, s_valid, s_ready     : per-channel sample streams
//   fft_iaddr, fft_iReal, fft_iImag,
//   fft_ien                              : core load side
//   fft_oReal, fft_oImag, fft_oaddr,
//   fft_oen                              : core result side
//   r_real, r_imag, r_addr, r_valid, r_id: tagged result stream
//   done[1:0]                            : one-cycle end-of-frame pulse
//   err                                  : sticky watchdog timeout flag
//
// state    | meaning
// ST_IDLE  | no frame in the core; arbitrate pending requests
// ST_LOAD  | granted channel streams N samples into the core
// ST_WAIT  | load finished; watchdog runs until the first result beat
// ST_DRAIN | forward result beats until N have been sent
module fft_arb
  import fft_arb_pkg::*;
#(
  parameter int STAGE   = TOTAL_STAGE,
  parameter int RW      = REAL_WIDTH,
  parameter int IW      = IMGN_WIDTH,
  parameter int TIMEOUT = fft_timeout(STAGE)
) (
  input  logic                iclk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  output logic [1:0]          gnt,
  input  logic [1:0][RW-1:0]  s_real,
  input  logic [1:0][IW-1:0]  s_imag,
  input  logic [1:0]          s_valid,
  output logic [1:0]          s_ready,
  output logic [STAGE-1:0]    fft_iaddr,
  output logic [RW-1:0]       fft_iReal,
  output logic [IW-1:0]       fft_iImag,
  output logic                fft_ien,
  input  logic [RW-1:0]       fft_oReal,
  input  logic [IW-1:0]       fft_oImag,
  input  logic [STAGE-1:0]    fft_oaddr,
  input  logic                fft_oen,
  output logic [RW-1:0]       r_real,
  output logic [IW-1:0]       r_imag,
  output logic [STAGE-1:0]    r_addr,
  output logic                r_valid,
  output logic                r_id,
  output logic [1:0]          done,
  output logic                err
);

  localparam int N   = 1 << STAGE;
  localparam int CW  = STAGE + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

  arb_state_e state_q, state_d;

  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       s_ready_q, s_ready_d;
  logic [CW-1:0]    ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;

  logic [STAGE-1:0] fft_iaddr_q, fft_iaddr_d;
  logic [RW-1:0]    fft_ireal_q, fft_ireal_d;
  logic [IW-1:0]    fft_iimag_q, fft_iimag_d;
  logic             fft_ien_q, fft_ien_d;

  logic [RW-1:0]    r_real_q, r_real_d;
  logic [IW-1:0]    r_imag_q, r_imag_d;
  logic [STAGE-1:0] r_addr_q, r_addr_d;
  logic             r_valid_q, r_valid_d;
  logic             r_id_q, r_id_d;

  logic [1:0]       done_q, done_d;
  logic             err_q, err_d;

  logic [1:0]       arb_grant;
  logic             arb_update;
  logic             ch;
  logic             xfer;

  rr_arb2 u_rr_arb2 (
    .iclk   (iclk),
    .rst_n  (rst_n),
    .req    (req),
    .update (arb_update),
    .grant  (arb_grant)
  );

  // gnt_q is one-hot while a frame is active, so bit 1 is the channel index.
  assign ch   = gnt_q[1];
  assign xfer = (state_q == ST_LOAD) && s_valid[ch] && s_ready_q[ch];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ld_cnt_d    = ld_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    fft_iaddr_d = fft_iaddr_q;
    fft_ireal_d = fft_ireal_q;
    fft_iimag_d = fft_iimag_q;
    fft_ien_d   = 1'b0;
    r_real_d    = r_real_q;
    r_imag_d    = r_imag_q;
    r_addr_d    = r_addr_q;
    r_id_d      = r_id_q;
    r_valid_d   = 1'b0;
    done_d      = 2'b00;
    err_d       = err_q;
    arb_update  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          arb_update = 1'b1;
          gnt_d      = arb_grant;
          err_d      = 1'b0;
          ld_cnt_d   = '0;
          state_d    = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (xfer) begin
          fft_ien_d   = 1'b1;
          fft_iaddr_d = ld_cnt_q[STAGE-1:0];
          fft_ireal_d = s_real[ch];
          fft_iimag_d = s_imag[ch];
          ld_cnt_d    = ld_cnt_q + CW'(1);
          if (ld_cnt_q == CNT_LAST) begin
            wd_cnt_d = '0;
            state_d  = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (fft_oen) begin
          // The first result beat is forwarded immediately as result 0.
          r_real_d  = fft_oReal;
          r_imag_d  = fft_oImag;
          r_addr_d  = fft_oaddr;
          r_id_d    = ch;
          r_valid_d = 1'b1;
          rd_cnt_d  = CW'(1);
          state_d   = ST_DRAIN;
        end else if (wd_cnt_q == WD_LAST) begin
          err_d   = 1'b1;
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WDW'(1);
        end
      end

      ST_DRAIN: begin
        if (fft_oen) begin
          r_real_d  = fft_oReal;
          r_imag_d  = fft_oImag;
          r_addr_d  = fft_oaddr;
          r_id_d    = ch;
          r_valid_d = 1'b1;
          rd_cnt_d  = rd_cnt_q + CW'(1);
          if (rd_cnt_q == CNT_LAST) begin
            done_d  = gnt_q;
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    // Registered ready follows the next state so it drops on the LOAD exit edge.
    s_ready_d = (state_d == ST_LOAD) ? gnt_d : 2'b00;
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 2'b00;
      s_ready_q   <= 2'b00;
      ld_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wd_cnt_q    <= '0;
      fft_iaddr_q <= '0;
      fft_ireal_q <= '0;
      fft_iimag_q <= '0;
      fft_ien_q   <= 1'b0;
      r_real_q    <= '0;
      r_imag_q    <= '0;
      r_addr_q    <= '0;
      r_valid_q   <= 1'b0;
      r_id_q      <= 1'b0;
      done_q      <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      s_ready_q   <= s_ready_d;
      ld_cnt_q    <= ld_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      fft_iaddr_q <= fft_iaddr_d;
      fft_ireal_q <= fft_ireal_d;
      fft_iimag_q <= fft_iimag_d;
      fft_ien_q   <= fft_ien_d;
      r_real_q    <= r_real_d;
      r_imag_q    <= r_imag_d;
      r_addr_q    <= r_addr_d;
      r_valid_q   <= r_valid_d;
      r_id_q      <= r_id_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign s_ready   = s_ready_q;
  assign fft_iaddr = fft_iaddr_q;
  assign fft_iReal = fft_ireal_q;
  assign fft_iImag = fft_iimag_q;
  assign fft_ien   = fft_ien_q;
  assign r_real    = r_real_q;
  assign r_imag    = r_imag_q;
  assign r_addr    = r_addr_q;
  assign r_valid   = r_valid_q;
  assign r_id      = r_id_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fft_arb.sv
// tb_fft_arb
// Directed bench for fft_arb (STAGE=4, TIMEOUT=64). Stimulus tasks push
// expected load beats, result beats and done pulses into queues; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
module tb_fft_arb;

  localparam int STAGE = 4;
  localparam int RW    = 16;
  localparam int IW    = 16;
  localparam int TMO   = 64;
  localparam int N     = 1 << STAGE;

  typedef struct packed {
    logic [STAGE-1:0] addr;
    logic [RW-1:0]    re;
    logic [IW-1:0]    im;
    logic             id;
  } beat_t;

  logic                iclk = 1'b0;
  logic                rst_n;
  logic [1:0]          req;
  logic [1:0]          gnt;
  logic [1:0][RW-1:0]  s_real;
  logic [1:0][IW-1:0]  s_imag;
  logic [1:0]          s_valid;
  logic [1:0]          s_ready;
  logic [STAGE-1:0]    fft_iaddr;
  logic [RW-1:0]       fft_iReal;
  logic [IW-1:0]       fft_iImag;
  logic                fft_ien;
  logic [RW-1:0]       fft_oReal;
  logic [IW-1:0]       fft_oImag;
  logic [STAGE-1:0]    fft_oaddr;
  logic                fft_oen;
  logic [RW-1:0]       r_real;
  logic [IW-1:0]       r_imag;
  logic [STAGE-1:0]    r_addr;
  logic                r_valid;
  logic                r_id;
  logic [1:0]          done;
  logic                err;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  beat_t      load_q[$];
  beat_t      res_q[$];
  logic [1:0] done_q[$];

  fft_arb #(.STAGE(STAGE), .RW(RW), .IW(IW), .TIMEOUT(TMO)) dut (
    .iclk(iclk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .s_real(s_real), .s_imag(s_imag), .s_valid(s_valid), .s_ready(s_ready),
    .fft_iaddr(fft_iaddr), .fft_iReal(fft_iReal), .fft_iImag(fft_iImag), .fft_ien(fft_ien),
    .fft_oReal(fft_oReal), .fft_oImag(fft_oImag), .fft_oaddr(fft_oaddr), .fft_oen(fft_oen),
    .r_real(r_real), .r_imag(r_imag), .r_addr(r_addr), .r_valid(r_valid), .r_id(r_id),
    .done(done), .err(err)
  );

  always #5 iclk = ~iclk;

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input int ch);
    return (ch == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [15:0] mk_sre(input int ch, input int fid, input int i);
    return 16'(32'hA000 + ch * 256 + fid * 16 + i);
  endfunction
  function automatic logic [15:0] mk_sim(input int ch, input int fid, input int i);
    return 16'(32'h5000 + ch * 256 + fid * 16 + (15 - i));
  endfunction
  function automatic logic [15:0] mk_ore(input int ch, input int fid, input int j);
    return 16'(32'h3000 + ch * 256 + fid * 16 + j);
  endfunction
  function automatic logic [15:0] mk_oim(input int ch, input int fid, input int j);
    return 16'(32'hC000 + ch * 256 + fid * 16 + (j ^ 5));
  endfunction

  // Scoreboard monitor.
  always @(negedge iclk) begin
    beat_t b;
    logic [1:0] d;
    if (rst_n === 1'b1) begin
      if (fft_ien === 1'b1) begin
        if (load_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL load_unexpected actual=ien@%0h required=no_load", fft_iaddr);
        end else begin
          b = load_q.pop_front();
          chk("load_addr", 32'(fft_iaddr), 32'(b.addr));
          chk("load_real", 32'(fft_iReal), 32'(b.re));
          chk("load_imag", 32'(fft_iImag), 32'(b.im));
        end
      end
      if (r_valid === 1'b1) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL result_unexpected actual=r_valid@%0h required=no_result", r_addr);
        end else begin
          b = res_q.pop_front();
          chk("res_addr", 32'(r_addr), 32'(b.addr));
          chk("res_real", 32'(r_real), 32'(b.re));
          chk("res_imag", 32'(r_imag), 32'(b.im));
          chk("res_id", 32'(r_id), 32'(b.id));
        end
      end
      if (done !== 2'b00) begin
        done_seen++;
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected actual=%0h required=00", done);
        end else begin
          d = done_q.pop_front();
          chk("done_value", 32'(done), 32'(d));
        end
      end
      if (gnt !== 2'b00) chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
    end
  end

  task automatic chk_zero(input string pfx);
    chk({pfx, "_gnt"}, 32'(gnt), 32'd0);
    chk({pfx, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({pfx, "_ien"}, 32'(fft_ien), 32'd0);
    chk({pfx, "_iaddr"}, 32'(fft_iaddr), 32'd0);
    chk({pfx, "_ireal"}, 32'(fft_iReal), 32'd0);
    chk({pfx, "_iimag"}, 32'(fft_iImag), 32'd0);
    chk({pfx, "_r_valid"}, 32'(r_valid), 32'd0);
    chk({pfx, "_r_real"}, 32'(r_real), 32'd0);
    chk({pfx, "_r_imag"}, 32'(r_imag), 32'd0);
    chk({pfx, "_r_addr"}, 32'(r_addr), 32'd0);
    chk({pfx, "_r_id"}, 32'(r_id), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    chk({pfx, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge iclk);
    rst_n = 1'b0;
    req = 2'b00; s_valid = 2'b00; s_real = '0; s_imag = '0;
    fft_oen = 1'b0; fft_oReal = '0; fft_oImag = '0; fft_oaddr = '0;
    load_q.delete(); res_q.delete(); done_q.delete();
    repeat (2) @(negedge iclk);
    chk_zero("rst");
    rst_n = 1'b1;
    @(negedge iclk);
  endtask

  // Called on a falling edge right after req changes.
  task automatic wait_gnt(input logic [1:0] exp, input string nm, output int lat);
    lat = 0;
    while (gnt === 2'b00 && lat < 20) begin
      @(posedge iclk); lat++; @(negedge iclk);
    end
    chk(nm, 32'(gnt), 32'(exp));
  endtask

  // Streams up to nmax samples of channel ch; skip_a/skip_b insert one idle
  // cycle before that sample index. Entered and left on a falling edge.
  task automatic load_frame(input int ch, input int fid, input int skip_a,
                            input int skip_b, input int nmax, output int cyc);
    int  i = 0;
    bit  sa = 0, sb = 0, gap = 0;
    cyc = 0;
    while (i < nmax && cyc < 60) begin
      if (gap) begin
        chk("ien_gap", 32'(fft_ien), 32'd0);
        chk("iaddr_hold", 32'(fft_iaddr), 32'(i - 1));
        gap = 0;
      end
      if (i == skip_a && !sa) begin
        sa = 1; gap = 1; s_valid[ch] = 1'b0;
      end else if (i == skip_b && !sb) begin
        sb = 1; gap = 1; s_valid[ch] = 1'b0;
      end else begin
        s_valid[ch] = 1'b1;
        s_real[ch]  = mk_sre(ch, fid, i);
        s_imag[ch]  = mk_sim(ch, fid, i);
        if (i == 0 || i == 8) chk("s_ready_granted", 32'(s_ready), 32'(onehot(ch)));
        load_q.push_back('{addr: STAGE'(i), re: mk_sre(ch, fid, i),
                           im: mk_sim(ch, fid, i), id: 1'b0});
        i++;
      end
      @(posedge iclk); cyc++; @(negedge iclk);
    end
    s_valid = 2'b00;
    if (nmax == N) chk("s_ready_drop", 32'(s_ready), 32'd0);
  endtask

  // Acts as the core: N result beats with one idle beat at index gap_at.
  task automatic drain_frame(input int ch, input int fid, input int gap_at);
    repeat (3) @(negedge iclk);
    for (int j = 0; j < N; j++) begin
      if (j == gap_at) begin
        fft_oen = 1'b0;
        @(posedge iclk); @(negedge iclk);
      end
      fft_oen   = 1'b1;
      fft_oaddr = STAGE'(j);
      fft_oReal = mk_ore(ch, fid, j);
      fft_oImag = mk_oim(ch, fid, j);
      res_q.push_back('{addr: STAGE'(j), re: mk_ore(ch, fid, j),
                        im: mk_oim(ch, fid, j), id: ch[0]});
      if (j == N - 1) done_q.push_back(onehot(ch));
      @(posedge iclk); @(negedge iclk);
    end
    fft_oen = 1'b0;
    chk("gnt_clear", 32'(gnt), 32'd0);
  endtask

  initial begin
    int lat, cyc, k, dseen;
    rst_n = 1'b0;
    req = 2'b00; s_valid = 2'b00; s_real = '0; s_imag = '0;
    fft_oen = 1'b0; fft_oReal = '0; fft_oImag = '0; fft_oaddr = '0;

    // Basic frame on channel 0; req dropped mid-frame.
    do_reset();
    req = 2'b01;
    wait_gnt(2'b01, "t1_gnt", lat);
    chk("t1_gnt_latency", 32'(lat), 32'd1);
    load_frame(0, 1, -1, -1, N, cyc);
    chk("t1_load_cycles", 32'(cyc), 32'd16);
    req = 2'b00;
    drain_frame(0, 1, 7);
    repeat (3) @(negedge iclk);
    chk("t1_no_regrant", 32'(gnt), 32'd0);

    // Both channels requesting for three frames: 01, 10, 01.
    do_reset();
    req = 2'b11;
    for (int f = 0; f < 3; f++) begin
      wait_gnt((f == 1) ? 2'b10 : 2'b01, "t2_rr_gnt", lat);
      load_frame(f % 2, 2 + f, -1, -1, N, cyc);
      drain_frame(f % 2, 2 + f, -1);
    end
    req = 2'b00;
    repeat (2) @(negedge iclk);

    // Source stalls before samples 5 and 9.
    do_reset();
    req = 2'b01;
    wait_gnt(2'b01, "t3_gnt", lat);
    load_frame(0, 5, 5, 9, N, cyc);
    chk("t3_load_cycles", 32'(cyc), 32'd18);
    req = 2'b00;
    drain_frame(0, 5, -1);

    // Core never answers: watchdog fires after TIMEOUT cycles in WAIT.
    do_reset();
    req = 2'b01;
    wait_gnt(2'b01, "t4_gnt", lat);
    load_frame(0, 6, -1, -1, N, cyc);
    req = 2'b00;
    dseen = done_seen;
    k = 0;
    while (err !== 1'b1 && k < 100) begin
      @(posedge iclk); k++; @(negedge iclk);
    end
    chk("t4_timeout_cycles", 32'(k), 32'(TMO));
    chk("t4_timeout_gnt", 32'(gnt), 32'd0);
    repeat (3) @(negedge iclk);
    chk("t4_err_sticky", 32'(err), 32'd1);
    chk("t4_no_done", 32'(done_seen), 32'(dseen));
    req = 2'b10;
    wait_gnt(2'b10, "t4_regrant", lat);
    chk("t4_err_cleared", 32'(err), 32'd0);
    load_frame(1, 7, -1, -1, N, cyc);
    req = 2'b00;
    drain_frame(1, 7, 3);

    // Reset at load count 7, then stray core output, then recovery.
    do_reset();
    req = 2'b01;
    wait_gnt(2'b01, "t5_gnt", lat);
    load_frame(0, 8, -1, -1, 7, cyc);
    #2 rst_n = 1'b0;
    #1 chk_zero("t5_async");
    req = 2'b00;
    load_q.delete(); res_q.delete(); done_q.delete();
    repeat (2) @(negedge iclk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      fft_oen = 1'b1; fft_oaddr = STAGE'(j); fft_oReal = 16'h7777; fft_oImag = 16'h8888;
      @(posedge iclk); @(negedge iclk);
      chk("t5_stray_r_valid", 32'(r_valid), 32'd0);
    end
    fft_oen = 1'b0;
    req = 2'b11;
    wait_gnt(2'b01, "t5_ptr_reset", lat);
    load_frame(0, 9, -1, -1, N, cyc);
    req = 2'b00;
    drain_frame(0, 9, -1);

    repeat (3) @(negedge iclk);
    chk("end_load_q_empty", 32'(load_q.size()), 32'd0);
    chk("end_res_q_empty", 32'(res_q.size()), 32'd0);
    chk("end_done_q_empty", 32'(done_q.size()), 32'd0);
    chk("end_done_count", 32'(done_seen), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_arb.md
FFT_ARB -- requirements
Module: fft_arb

Interface
REQ-001 SHALL have parameter STAGE, default `TOTAL_STAGE, frame length N = 2^STAGE points.
REQ-002 SHALL have parameter RW, default `REAL_WIDTH, real sample width.
REQ-003 SHALL have parameter IW, default `IMGN_WIDTH, imaginary sample width.
REQ-004 SHALL have parameter TIMEOUT, default 4*N, WAIT-state watchdog limit in cycles.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: iclk  in  1  clock, all logic on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports req  in  2  per-channel frame request; gnt  out  2  one-hot grant.
REQ-007 SHALL have ports s_real[c]  in  RW, s_imag[c]  in  IW, s_valid[c]  in  1, s_ready[c]  out  1, per-channel sample stream, c=0,1.
REQ-008 SHALL have ports fft_iaddr  out  STAGE, fft_iReal  out  RW, fft_iImag  out  IW, fft_ien  out  1, load side of the fft core.
REQ-009 SHALL have ports fft_oReal  in  RW, fft_oImag  in  IW, fft_oaddr  in  STAGE, fft_oen  in  1, result side of the fft core.
REQ-010 SHALL have ports r_real  out  RW, r_imag  out  IW, r_addr  out  STAGE, r_valid  out  1, r_id  out  1, tagged result stream.
REQ-011 SHALL have ports done  out  2 (one-cycle pulse per channel) and err  out  1 (sticky timeout flag, cleared by the next grant).

Function
REQ-012 SHALL implement FSM IDLE -> LOAD -> WAIT -> DRAIN -> IDLE; one frame in the core at a time.
REQ-013 IDLE: if any req is high, SHALL grant round-robin (priority to the channel not granted last; channel 0 first after reset), assert gnt next cycle, enter LOAD with load counter cleared.
REQ-014 LOAD: s_ready[g] SHALL equal 1 for the granted channel g only; a sample transfers when s_valid[g] and s_ready[g] are both high.
REQ-015 On each transfer, fft_ien SHALL be 1 with fft_iaddr = load count and fft_iReal/fft_iImag = sample, all registered (1-cycle latency); on no transfer, fft_ien = 0 and fft_iaddr holds.
REQ-016 On transfer N-1, LOAD SHALL exit to WAIT; s_ready drops in the same cycle as the exit.
REQ-017 WAIT: SHALL count cycles; first cycle with fft_oen=1 enters DRAIN and that beat counts as result 0; count reaching TIMEOUT sets err, pulses no done, clears gnt, returns to IDLE.
REQ-018 DRAIN: each fft_oen=1 cycle SHALL forward fft_oReal/oImag/oaddr to r_real/r_imag/r_addr, with r_valid=1 and r_id=g, registered 1 cycle; fft_oen=0 beats are skipped.
REQ-019 After N forwarded beats, SHALL pulse done[g] one cycle, clear gnt, return to IDLE; the next grant is evaluated in that IDLE cycle.
REQ-020 req deassert during LOAD/WAIT/DRAIN SHALL be ignored: the frame completes.
REQ-021 fft_oen=1 while in IDLE or LOAD SHALL be ignored: r_valid stays 0.
REQ-022 Counters SHALL be STAGE+1 bits to detect N without wrap; the watchdog counter SHALL be sized as clog2(TIMEOUT+1).

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, gnt=0, s_ready=0, fft_ien=0, fft_iaddr=0, fft_iReal=0, fft_iImag=0, r_valid=0, r_real/r_imag/r_addr/r_id=0, done=0, err=0, round-robin pointer to channel 0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no done pulse; after release, the block SHALL ignore core output until a new LOAD completes.

Structure
REQ-025 SHALL take STAGE/RW/IW defaults from fft_inc.h; FSM state encodings and the TIMEOUT default SHALL be added to fft_inc.h.
REQ-026 SHALL instantiate one sub-module rr_arb2 (two-way round-robin arbiter with a last-grant register); the FSM, counters, and muxes stay in fft_arb.

Verification
REQ-027 STAGE=4, req=01, s_valid[0] high 16 cycles -> gnt=01 1 cycle later; fft_ien high 16 cycles with fft_iaddr 0..15; model core output -> 16 r_valid beats, r_id=0, done[0] pulses once.
REQ-028 req=11 held for three frames -> grants 01, 10, 01 in that order; no overlap of gnt bits.
REQ-029 s_valid[0] low at samples 5 and 9 -> fft_ien low those cycles, fft_iaddr holds at 5 and 9; LOAD completes after 18 cycles.
REQ-030 Core never asserts fft_oen, TIMEOUT=64 -> err=1 64 cycles after entering WAIT, gnt=00, no done; the next grant clears err.
REQ-031 rst_n low at load count 7 -> all outputs are zero immediately (before the next edge); a stray fft_oen after release -> r_valid stays 0.
